// File: rtl/mccpu_ctrl.sv
// Multicycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencer with a memory wait-timeout.
// Strobes decode combinationally from the state and the inputs; they are forced to 0 while rst is high.
module mccpu_ctrl #(
    parameter int CNT_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_NOR   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_SLLV  = 4'b1011;
    localparam logic [3:0] ALU_SRLV  = 4'b1100;
    localparam logic [3:0] ALU_SLL16 = 4'b1101;

    localparam logic [1:0] NPC_PLUS4 = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_J     = 2'b10;
    localparam logic [1:0] NPC_JR    = 2'b11;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam bit               TO_EN    = (WAIT_MAX != 0);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;

    logic       dec_legal;
    logic       is_alu_r;
    logic       is_alu_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic       is_jalr;
    logic       use_shamt;
    logic       ext_imm;
    logic [3:0] alu_op;

    logic in_access;
    logic timeout;
    logic waiting;

    assign state = cur;

    always_comb begin
        dec_legal = 1'b0;
        is_alu_r  = 1'b0;
        is_alu_i  = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        is_jalr   = 1'b0;
        use_shamt = 1'b0;
        ext_imm   = 1'b0;
        alu_op    = ALU_NOP;
        case (Op)
            6'b000000: begin
                dec_legal = 1'b1;
                is_alu_r  = 1'b1;
                case (Funct)
                    6'b100000, 6'b100001: alu_op = ALU_ADD;
                    6'b100010, 6'b100011: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b100111: alu_op = ALU_NOR;
                    6'b101010: alu_op = ALU_SLT;
                    6'b101011: alu_op = ALU_SLTU;
                    6'b000000: begin alu_op = ALU_SLL; use_shamt = 1'b1; end
                    6'b000010: begin alu_op = ALU_SRL; use_shamt = 1'b1; end
                    6'b000011: begin alu_op = ALU_SRA; use_shamt = 1'b1; end
                    6'b000100: alu_op = ALU_SLLV;
                    6'b000110: alu_op = ALU_SRLV;
                    6'b001000: begin is_alu_r = 1'b0; is_jr = 1'b1; end
                    6'b001001: begin is_alu_r = 1'b0; is_jalr = 1'b1; end
                    default: begin dec_legal = 1'b0; is_alu_r = 1'b0; end
                endcase
            end
            6'b001000: begin dec_legal = 1'b1; is_alu_i = 1'b1; alu_op = ALU_ADD;   ext_imm = 1'b1; end
            6'b001101: begin dec_legal = 1'b1; is_alu_i = 1'b1; alu_op = ALU_OR;    end
            6'b001010: begin dec_legal = 1'b1; is_alu_i = 1'b1; alu_op = ALU_SLT;   ext_imm = 1'b1; end
            6'b001111: begin dec_legal = 1'b1; is_alu_i = 1'b1; alu_op = ALU_SLL16; end
            6'b100011: begin dec_legal = 1'b1; is_lw  = 1'b1; end
            6'b101011: begin dec_legal = 1'b1; is_sw  = 1'b1; end
            6'b000100: begin dec_legal = 1'b1; is_beq = 1'b1; end
            6'b000101: begin dec_legal = 1'b1; is_bne = 1'b1; end
            6'b000010: begin dec_legal = 1'b1; is_j   = 1'b1; end
            6'b000011: begin dec_legal = 1'b1; is_jal = 1'b1; end
            default:   dec_legal = 1'b0;
        endcase
    end

    // mem_ready takes priority over an expiring wait budget in the same cycle.
    assign in_access = (cur == S_IF) || (cur == S_MEM);
    assign timeout   = TO_EN && in_access && !mem_ready && (cnt == WAIT_LIM);
    assign waiting   = in_access && !mem_ready && !timeout;

    always_comb begin
        nxt      = S_IF;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PLUS4;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        illegal  = 1'b0;
        mem_err  = 1'b0;
        if (!rst) begin
            case (cur)
                S_IF: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        nxt     = S_ID;
                    end else if (timeout) begin
                        mem_err = 1'b1;
                    end
                end
                S_ID: begin
                    if (dec_legal) nxt = S_EXE;
                    else           illegal = 1'b1;
                end
                S_EXE: begin
                    if (is_alu_r || is_alu_i) begin
                        ALUOp   = alu_op;
                        ALUSrcA = use_shamt;
                        ALUSrcB = is_alu_i;
                        EXTOp   = ext_imm;
                        nxt     = S_WB;
                    end else if (is_lw || is_sw) begin
                        ALUOp   = ALU_ADD;
                        ALUSrcB = 1'b1;
                        EXTOp   = 1'b1;
                        nxt     = S_MEM;
                    end else if (is_beq || is_bne) begin
                        ALUOp = ALU_SUB;
                        if ((is_beq && Zero) || (is_bne && !Zero)) begin
                            PCWrite = 1'b1;
                            NPCOp   = NPC_BR;
                        end
                    end else if (is_j || is_jal || is_jr || is_jalr) begin
                        PCWrite = 1'b1;
                        NPCOp   = (is_jr || is_jalr) ? NPC_JR : NPC_J;
                        if (is_jal || is_jalr) begin
                            RegWrite = 1'b1;
                            GPRSel   = 2'b10;
                            WDSel    = 2'b10;
                        end
                    end
                end
                S_MEM: begin
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                    if (mem_ready)    nxt = is_lw ? S_WB : S_IF;
                    else if (timeout) mem_err = 1'b1;
                    else if (is_lw || is_sw) nxt = S_MEM;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    if (is_lw) begin
                        GPRSel = 2'b01;
                        WDSel  = 2'b01;
                    end else if (is_alu_i) begin
                        GPRSel = 2'b01;
                    end
                end
                default: nxt = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IF;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (waiting) cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
            else         cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed bench for mccpu_ctrl (WAIT_MAX=3): per-cycle state/strobe/control checks.
module tb_mccpu_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp;
    logic       ALUSrcA, ALUSrcB;
    logic [1:0] GPRSel, WDSel;
    logic [2:0] state;
    logic       illegal, mem_err;

    int total = 0;
    int bad   = 0;

    mccpu_ctrl #(.CNT_W(4), .WAIT_MAX(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel),
        .state(state), .illegal(illegal), .mem_err(mem_err)
    );

    // stb = {PCWrite,IRWrite,MemRead,MemWrite,RegWrite}
    // ctl = {EXTOp,ALUOp[3:0],NPCOp[1:0],ALUSrcA,ALUSrcB,GPRSel[1:0],WDSel[1:0]}
    logic [4:0]  stb;
    logic [12:0] ctl;
    assign stb = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};
    assign ctl = {EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] s,
                       input logic [12:0] c);
        chk({tag, ".state"}, 16'(state), 16'(st));
        chk({tag, ".stb"},   16'(stb),   16'(s));
        chk({tag, ".ctl"},   16'(ctl),   16'(c));
    endtask

    task automatic flags(input string tag, input logic ill, input logic err);
        chk({tag, ".flags"}, 16'({illegal, mem_err}), 16'({ill, err}));
    endtask

    initial begin
        rst = 1'b1; Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        cyc("rst", 3'd0, 5'b00000, 13'd0);
        flags("rst", 1'b0, 1'b0);

        // add, zero wait: IF ID EXE WB
        rst = 1'b0; #1;
        cyc("add.IF", 3'd0, 5'b11100, 13'd0);             tick();
        cyc("add.ID", 3'd1, 5'b00000, 13'd0);
        flags("add.ID", 1'b0, 1'b0);                      tick();
        cyc("add.EXE", 3'd2, 5'b00000, 13'b0_0001_00_0_0_00_00); tick();
        cyc("add.WB", 3'd4, 5'b00001, 13'd0);             tick();

        // lw with three wait cycles; the ready on the 4th arrives exactly at the timeout count
        Op = 6'b100011; #1;
        cyc("lw.IF", 3'd0, 5'b11100, 13'd0);              tick();
        cyc("lw.ID", 3'd1, 5'b00000, 13'd0);              tick();
        mem_ready = 1'b0; #1;
        cyc("lw.EXE", 3'd2, 5'b00000, 13'b1_0001_00_0_1_00_00); tick();
        for (int i = 0; i < 3; i++) begin
            cyc("lw.MEMwait", 3'd3, 5'b00100, 13'd0);
            flags("lw.MEMwait", 1'b0, 1'b0);
            tick();
        end
        mem_ready = 1'b1; #1;
        cyc("lw.MEMrdy", 3'd3, 5'b00100, 13'd0);
        flags("lw.MEMrdy", 1'b0, 1'b0);                   tick();
        cyc("lw.WB", 3'd4, 5'b00001, 13'b0_0000_00_0_0_01_01); tick();

        // beq taken then not taken
        Op = 6'b000100; Zero = 1'b1; #1;
        cyc("beq1.IF", 3'd0, 5'b11100, 13'd0);            tick(); tick();
        cyc("beq1.EXE", 3'd2, 5'b10000, 13'b0_0010_01_0_0_00_00); tick();
        Zero = 1'b0; #1;
        cyc("beq0.IF", 3'd0, 5'b11100, 13'd0);            tick(); tick();
        cyc("beq0.EXE", 3'd2, 5'b00000, 13'b0_0010_00_0_0_00_00); tick();
        cyc("beq0.back", 3'd0, 5'b11100, 13'd0);

        // jal
        Op = 6'b000011; #1;                               tick(); tick();
        cyc("jal.EXE", 3'd2, 5'b10001, 13'b0_0000_10_0_0_10_10); tick();

        // sll uses shamt
        Op = 6'b000000; Funct = 6'b000000; #1;            tick(); tick();
        cyc("sll.EXE", 3'd2, 5'b00000, 13'b0_1000_00_1_0_00_00); tick();
        cyc("sll.WB", 3'd4, 5'b00001, 13'd0);             tick();

        // ori: zero-extended immediate, rt destination
        Op = 6'b001101; #1;                               tick(); tick();
        cyc("ori.EXE", 3'd2, 5'b00000, 13'b0_0100_00_0_1_00_00); tick();
        cyc("ori.WB", 3'd4, 5'b00001, 13'b0_0000_00_0_0_01_00); tick();

        // jr
        Op = 6'b000000; Funct = 6'b001000; #1;            tick(); tick();
        cyc("jr.EXE", 3'd2, 5'b10000, 13'b0_0000_11_0_0_00_00); tick();

        // illegal opcode
        Op = 6'b111111; #1;                               tick();
        cyc("ill.ID", 3'd1, 5'b00000, 13'd0);
        flags("ill.ID", 1'b1, 1'b0);                      tick();
        cyc("ill.next", 3'd0, 5'b11100, 13'd0);
        flags("ill.next", 1'b0, 1'b0);

        // fetch timeout twice in a row: counter must restart from 0 after the first
        mem_ready = 1'b0; #1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                cyc("to.IFwait", 3'd0, 5'b00100, 13'd0);
                flags("to.IFwait", 1'b0, 1'b0);
                tick();
            end
            cyc("to.IFexp", 3'd0, 5'b00100, 13'd0);
            flags("to.IFexp", 1'b0, 1'b1);
            tick();
        end
        cyc("to.after", 3'd0, 5'b00100, 13'd0);
        flags("to.after", 1'b0, 1'b0);

        // sw interrupted by reset in MEM
        Op = 6'b101011; mem_ready = 1'b1; #1;             tick(); tick();
        cyc("sw.EXE", 3'd2, 5'b00000, 13'b1_0001_00_0_1_00_00);
        mem_ready = 1'b0;                                 tick();
        cyc("sw.MEM", 3'd3, 5'b00010, 13'd0);
        rst = 1'b1; #1;
        chk("sw.rsthigh.stb", 16'(stb), 16'(5'b00000));   tick();
        cyc("sw.rst", 3'd0, 5'b00000, 13'd0);
        flags("sw.rst", 1'b0, 1'b0);
        rst = 1'b0; #1;
        cyc("sw.IF", 3'd0, 5'b00100, 13'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
